// File: rtl/mux_stream_pkg.sv
// Shared channel count and index/mask types for the 4-channel stream arbiter.
package mux_stream_pkg;

    localparam int NCH = 4;

    typedef logic [1:0]     ch_idx_t;
    typedef logic [NCH-1:0] ch_mask_t;

endpackage : mux_stream_pkg

// File: rtl/mux2.sv
// Plain 2:1 word multiplexer; s=0 passes a, s=1 passes b.
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule : mux2

// File: rtl/rr_pick4.sv
// Round-robin picker: the first requester at or after ptr (mod 4) wins.
// Rotates req so ptr lands on bit 0, takes the lowest set bit, rotates back.
// With no request, gnt is zero and idx holds ptr.
module rr_pick4
    import mux_stream_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx
);

    ch_mask_t rot;
    ch_idx_t  offset;
    logic     found;

    // Rotate, priority-encode the lowest set bit, then map back to a channel index.
    always_comb begin
        rot    = '0;
        offset = '0;
        found  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            rot[k] = req[ch_idx_t'(ptr + ch_idx_t'(k))];
        end
        // Descending scan so the lowest rotated position is the last write.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = ch_idx_t'(k);
                found  = 1'b1;
            end
        end
        idx = found ? ch_idx_t'(ptr + offset) : ptr;
        gnt = found ? (ch_mask_t'(1) << idx) : '0;
    end

endmodule : rr_pick4

// File: rtl/rr_mux4_arbiter.sv
// Round-robin 4:1 stream arbiter with a single registered output stage.
// Handshake: a transfer on any valid/ready pair happens on the clock edge
// where both valid and ready are high; producers hold valid and data until
// that edge. in_ready is driven only from grant and output-stage occupancy,
// never from data, and is forced low during reset.
module rr_mux4_arbiter
    import mux_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready,
    output logic [1:0]       sel
);

    ch_idx_t          ptr;
    ch_mask_t         gnt;
    ch_idx_t          idx;
    logic             load_en;
    logic             accept;
    logic [WIDTH-1:0] mux_lo;
    logic [WIDTH-1:0] mux_hi;
    logic [WIDTH-1:0] mux_out;

    rr_pick4 u_pick (
        .req (in_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx)
    );

    assign sel = idx;

    // The output register can take a word when empty or being drained now.
    assign load_en  = !out_valid || out_ready;
    assign in_ready = reset ? '0 : (gnt & {NCH{load_en}});
    // gnt is only ever set on a valid channel, so any ready bit is a handshake.
    assign accept   = |(in_ready & in_valid);

    mux2 #(.WIDTH(WIDTH)) u_mux_lo (
        .a (in_data0),
        .b (in_data1),
        .s (sel[0]),
        .y (mux_lo)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux_hi (
        .a (in_data2),
        .b (in_data3),
        .s (sel[0]),
        .y (mux_hi)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux_out (
        .a (mux_lo),
        .b (mux_hi),
        .s (sel[1]),
        .y (mux_out)
    );

    // Output stage and round-robin pointer: load on accept, empty on a bare drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_out;
            out_src   <= sel;
            ptr       <= ch_idx_t'(sel + 2'd1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : rr_mux4_arbiter

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: directed steps followed by a randomized run,
// with a cycle reference model and per-channel in-order scoreboard.
module tb_rr_mux4_arbiter;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [3:0]   in_valid;
    logic [W-1:0] din [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;
    logic [1:0]   sel;

    rr_mux4_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data0  (din[0]),
        .in_data1  (din[1]),
        .in_data2  (din[2]),
        .in_data3  (din[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model state ----------------
    int           m_ptr   = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_src   = 0;

    // Values observed just before the last active edge.
    logic [3:0]   cap_in_ready;
    logic [3:0]   cap_in_valid;
    logic         cap_out_valid;
    logic         cap_out_ready;
    logic [W-1:0] cap_out_data;
    logic [1:0]   cap_out_src;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q [4][$];
    bit           offering [4];
    int           wait_cnt [4];
    int           seq      [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First valid channel scanning ptr, ptr+1, ... mod 4; -1 if none.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs mid-cycle, step the model on the
    // edge, then check the registered outputs just after it.
    task automatic cycle();
        int           g;
        logic [3:0]   er;
        bit           le;
        logic [W-1:0] gd;
        @(negedge clk);
        g  = pick(in_valid, m_ptr);
        le = !m_valid || out_ready;
        er = (reset || g < 0 || !le) ? 4'b0000 : (4'b0001 << g);
        gd = (g >= 0) ? din[g] : '0;
        check("in_ready", in_ready, er);
        if (!reset) check("sel", sel, (g < 0) ? m_ptr : g);
        cap_in_ready  = in_ready;
        cap_in_valid  = in_valid;
        cap_out_valid = out_valid;
        cap_out_ready = out_ready;
        cap_out_data  = out_data;
        cap_out_src   = out_src;
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
        end else if (er != 4'b0000) begin
            m_valid = 1'b1;
            m_data  = gd;
            m_src   = g;
            m_ptr   = (g + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_src", out_src, m_src);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] held;
        int           c;
        reset     = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 8'hA0 + W'(i);

        // Reset held two cycles with every channel requesting.
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("rst_in_ready", cap_in_ready, 4'h0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_data", out_data, 8'h00);
        end
        reset = 1'b0;

        // Rotation with all four channels valid.
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rot_src", out_src, i % 4);
            check("rot_data", out_data, 8'hA0 + (i % 4));
        end

        // Park ptr at 3 via a lone ch2 accept, then skip idle channels.
        in_valid = 4'b0100;
        cycle();
        check("park_src", out_src, 2);
        in_valid = 4'b0101;
        cycle();
        check("skip_src0", out_src, 0);
        cycle();
        check("skip_src1", out_src, 2);
        cycle();
        check("skip_src2", out_src, 0);

        // Backpressure after one accept.
        in_valid = 4'hF;
        cycle();
        held = out_data;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_in_ready", cap_in_ready, 4'h0);
            check("bp_hold", out_data, held);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release", |cap_in_ready, 1'b1);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        cycle();
        check("stall_full", out_valid, 1'b1);
        reset = 1'b1;
        cycle();
        check("mid_rst_valid", out_valid, 1'b0);
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1010;
        cycle();
        check("post_rst_gnt", cap_in_ready, 4'b0010);
        check("post_rst_src", out_src, 1);

        // Clean restart for the randomized run.
        in_valid = 4'h0;
        reset    = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offering[i] = 1'b0;
            wait_cnt[i] = 0;
            seq[i]      = 0;
        end

        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!offering[i] && $urandom_range(0, 1) == 1) begin
                    offering[i] = 1'b1;
                    din[i]      = {2'(i), 6'(seq[i])};
                    seq[i]      = (seq[i] + 1) % 64;
                end
                in_valid[i] = offering[i];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            // Word leaving the output stage must be the oldest of its channel.
            if (cap_out_valid && cap_out_ready) begin
                if (exp_q[cap_out_src].size() == 0) begin
                    check("sb_dup", 1'b1, 1'b0);
                end else begin
                    check("sb_order", cap_out_data, exp_q[cap_out_src].pop_front());
                end
            end
            c = -1;
            for (int i = 0; i < 4; i++) if (cap_in_ready[i] && cap_in_valid[i]) c = i;
            if (c >= 0) begin
                exp_q[c].push_back(din[c]);
                check("fair_wait", wait_cnt[c] > 3, 1'b0);
                wait_cnt[c] = 0;
                offering[c] = 1'b0;
                for (int i = 0; i < 4; i++) if (i != c && offering[i]) wait_cnt[i]++;
            end
        end

        // Stop offering, then drain whatever is still in the output stage.
        in_valid  = 4'h0;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            if (cap_out_valid && cap_out_ready) begin
                if (exp_q[cap_out_src].size() == 0) begin
                    check("sb_dup", 1'b1, 1'b0);
                end else begin
                    check("sb_order", cap_out_data, exp_q[cap_out_src].pop_front());
                end
            end
        end
        for (int i = 0; i < 4; i++) check("sb_loss", exp_q[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rr_mux4_arbiter
